// File: rtl/ws2812_decoder.sv
// ---------------------------------------------------------------------------
// ws2812_decoder
//   Receive side of the WS2812 one-wire LED protocol. The data line is
//   synchronised, every high pulse is classified as a 0 or 1 by its length,
//   and bits are assembled MSB-first into 24-bit GRB words tagged with the
//   pixel index inside the frame. A long low period (reset gap) ends a frame.
//
//   Optional feature macro: WS2812_DEC_FORWARD_EN
//     When defined, a dout port is added and the block behaves like one strip
//     segment: the first NUM_LEDS pixels are consumed and everything after
//     them is forwarded (registered copy of the synchronised line).
// ---------------------------------------------------------------------------
module ws2812_decoder #(
    parameter int NUM_LEDS   = 8,
    parameter int CLK_MHZ    = 12,
    parameter int T_THRESH   = (CLK_MHZ * 625 + 999) / 1000,
    parameter int T_HIGH_MAX = CLK_MHZ * 5,
    parameter int T_RST_DET  = CLK_MHZ * 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic        overflow
`ifdef WS2812_DEC_FORWARD_EN
    ,
    output logic        dout
`endif
);

    // Counter width covers the longest interval we ever need to measure.
    localparam int CNT_BITS    = $clog2(T_RST_DET + 1);
    localparam int SYNC_STAGES = 3;

    localparam logic [CNT_BITS-1:0] C_THRESH   = CNT_BITS'(T_THRESH);
    localparam logic [CNT_BITS-1:0] C_HIGH_MAX = CNT_BITS'(T_HIGH_MAX);
    localparam logic [CNT_BITS-1:0] C_RST_DET  = CNT_BITS'(T_RST_DET);
    localparam logic [8:0]          C_NUM_LEDS = 9'(NUM_LEDS);
    localparam logic [4:0]          C_LAST_BIT = 5'd23;
    localparam logic [7:0]          C_PIX_SAT  = 8'hFF;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,   // waiting for a full reset gap before trusting the line
        ST_IDLE = 2'd1,   // gap seen, waiting for the first rising edge of a frame
        ST_RX   = 2'd2    // inside a frame, decoding bits
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser chain: stage 1 is din_s, stage 2 is the edge reference.
    // ------------------------------------------------------------------
    logic r_sync [SYNC_STAGES];

    // First synchroniser flop captures the asynchronous line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync[0] <= 1'b0;
        end else begin
            r_sync[0] <= din;
        end
    end

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        // Remaining stages of the shift chain.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync[gi] <= 1'b0;
            end else begin
                r_sync[gi] <= r_sync[gi-1];
            end
        end
    end

    logic w_din_s;
    logic w_din_q;
    logic w_rise;
    logic w_fall;

    assign w_din_s = r_sync[1];
    assign w_din_q = r_sync[2];
    assign w_rise  = w_din_s & ~w_din_q;
    assign w_fall  = ~w_din_s & w_din_q;

    // ------------------------------------------------------------------
    // Pulse-width counters. The edge cycle itself is the first counted
    // cycle, so at the falling edge r_hi_cnt equals the high width.
    // ------------------------------------------------------------------
    logic [CNT_BITS-1:0] r_hi_cnt;
    logic [CNT_BITS-1:0] r_lo_cnt;

    // High-time counter: restarts on rise, saturates at the fault limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi_cnt <= '0;
        end else if (w_rise) begin
            r_hi_cnt <= CNT_BITS'(1);
        end else if (w_din_s && (r_hi_cnt != C_HIGH_MAX)) begin
            r_hi_cnt <= r_hi_cnt + 1'b1;
        end
    end

    // Low-time counter: restarts on fall, saturates at the gap length.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo_cnt <= '0;
        end else if (w_fall) begin
            r_lo_cnt <= CNT_BITS'(1);
        end else if (!w_din_s && (r_lo_cnt != C_RST_DET)) begin
            r_lo_cnt <= r_lo_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Event decode.
    // The counters keep stale values across the opposite line level, so
    // the gap is only trusted while the line is steadily low (both
    // synchroniser taps low). This also guarantees a word-completing fall
    // and the gap detect can never fire in the same cycle.
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [22:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_pix_cnt;

    logic w_bit;
    logic w_gap;
    logic w_hi_fault;
    logic w_pix_in_range;

    assign w_bit          = (r_hi_cnt >= C_THRESH);
    assign w_gap          = (r_lo_cnt == C_RST_DET) && !w_din_s && !w_din_q;
    assign w_hi_fault     = (r_hi_cnt == C_HIGH_MAX);
    assign w_pix_in_range = ({1'b0, r_pix_cnt} < C_NUM_LEDS);

    logic [23:0] r_rgb_data;
    logic [7:0]  r_led_num;
    logic        r_valid;
    logic        r_frame_done;
    logic        r_frame_err;
    logic        r_overflow;

    // Frame FSM: bit assembly, pixel indexing and all status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_SYNC;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_rgb_data   <= '0;
            r_led_num    <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses.
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;

            case (r_state)
                ST_SYNC: begin
                    // Edges are ignored until the line has been low long
                    // enough to be sure we are between frames.
                    if (w_gap) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        r_pix_cnt <= '0;
                    end
                end

                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_RX;
                    end
                end

                ST_RX: begin
                    if (w_hi_fault) begin
                        // Line stuck high: drop the partial word and resync.
                        r_frame_err <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_state     <= ST_SYNC;
                    end else if (w_gap) begin
                        // End of frame: exactly one status pulse at most.
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end else if (r_pix_cnt != '0) begin
                            r_frame_done <= 1'b1;
                        end
                        r_bit_cnt <= '0;
                        r_pix_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else if (w_fall) begin
                        r_shift <= {r_shift[21:0], w_bit};
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (w_pix_in_range) begin
                                r_rgb_data <= {r_shift, w_bit};
                                r_led_num  <= r_pix_cnt;
                                r_valid    <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                            if (r_pix_cnt != C_PIX_SAT) begin
                                r_pix_cnt <= r_pix_cnt + 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

    assign rgb_data   = r_rgb_data;
    assign led_num    = r_led_num;
    assign valid      = r_valid;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

`ifdef WS2812_DEC_FORWARD_EN
    logic r_dout;

    // Strip-segment forwarding: once our own pixels are consumed, the
    // synchronised line is passed on one cycle later; quiet otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= 1'b0;
        end else if ((r_state == ST_RX) && !w_pix_in_range) begin
            r_dout <= w_din_s;
        end else begin
            r_dout <= 1'b0;
        end
    end

    assign dout = r_dout;
`endif

endmodule

// File: tb/tb_ws2812_decoder.sv
// ---------------------------------------------------------------------------
// tb_ws2812_decoder
//   Directed sequence of frames with randomised pixel data and pulse widths.
//   Expected results come from the protocol rules: a bit is 1 when its high
//   width reaches the threshold, the first NUM_LEDS complete words of a frame
//   are reported in order, later ones are overflow, and the gap reports
//   frame_done or frame_err depending on whether a word was left partial.
// ---------------------------------------------------------------------------
module tb_ws2812_decoder;

    localparam int NUM_LEDS   = 8;
    localparam int T_THRESH   = 8;     // 625 ns at 12 MHz, rounded up
    localparam int T_HIGH_MAX = 60;    // 5 us at 12 MHz
    localparam int GAP_LAT    = 603;   // 600 low cycles + 3 cycles of pipeline
    localparam int VALID_LAT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid;
    logic        frame_done;
    logic        frame_err;
    logic        overflow;
`ifdef WS2812_DEC_FORWARD_EN
    logic        dout;
`endif

    ws2812_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .valid      (valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow)
`ifdef WS2812_DEC_FORWARD_EN
        ,
        .dout       (dout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled on the falling edge.
    logic [23:0] v_rgb [0:255];
    logic [7:0]  v_led [0:255];
    int          v_cyc [0:255];
    int v_cnt  = 0;
    int d_cnt  = 0;
    int e_cnt  = 0;
    int o_cnt  = 0;
    int d_cyc  = 0;
    int dh_cnt = 0;

    always @(negedge clk) begin
        if (valid) begin
            v_rgb[v_cnt & 255] <= rgb_data;
            v_led[v_cnt & 255] <= led_num;
            v_cyc[v_cnt & 255] <= cyc;
            v_cnt <= v_cnt + 1;
        end
        if (frame_done) begin
            d_cnt <= d_cnt + 1;
            d_cyc <= cyc;
        end
        if (frame_err) e_cnt <= e_cnt + 1;
        if (overflow)  o_cnt <= o_cnt + 1;
`ifdef WS2812_DEC_FORWARD_EN
        if (dout) dh_cnt <= dh_cnt + 1;
`endif
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_pix  [0:15];
    int          pix_fall [0:15];
    int          last_fall = 0;
    int          fwd_exp   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rand_hi(input logic b);
        if (b) return int'($urandom_range(20, T_THRESH));
        else   return int'($urandom_range(T_THRESH - 1, 2));
    endfunction

    // One bit: high for hi cycles, then a short random low period.
    task automatic send_bit(input int hi);
        int lo;
        lo  = int'($urandom_range(12, 3));
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        last_fall = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w, input int nbits, input int first_hi, input bit fwd);
        int hi;
        for (int i = 0; i < nbits; i++) begin
            hi = (i == 0 && first_hi > 0) ? first_hi : rand_hi(w[23 - i]);
            if (fwd) fwd_exp += hi;
            send_bit(hi);
        end
    endtask

    // Sends n whole pixels from exp_pix plus an optional partial word,
    // holds the line low for a gap and checks everything the frame produced.
    task automatic run_frame(input string tag, input int n, input int partial, input int first_hi);
        int vb, db, eb, ob, dhb, nv, idx;
        logic [23:0] expw;
        vb = v_cnt; db = d_cnt; eb = e_cnt; ob = o_cnt; dhb = dh_cnt;
        fwd_exp = 0;
        for (int k = 0; k < n; k++) begin
            send_word(exp_pix[k], 24, (k == 0) ? first_hi : 0, k >= NUM_LEDS);
            pix_fall[k] = last_fall;
        end
        if (partial > 0) send_word(exp_pix[n], partial, 0, n >= NUM_LEDS);
        repeat (620) @(negedge clk);

        nv = (n < NUM_LEDS) ? n : NUM_LEDS;
        check($sformatf("%s valid_count", tag), 32'(v_cnt - vb), 32'(nv));
        for (int k = 0; k < nv; k++) begin
            idx  = (vb + k) & 255;
            expw = exp_pix[k];
            if (k == 0 && first_hi > 0) expw[23] = (first_hi >= T_THRESH);
            check($sformatf("%s rgb[%0d]", tag, k), 32'(v_rgb[idx]), 32'(expw));
            check($sformatf("%s led[%0d]", tag, k), 32'(v_led[idx]), 32'(k));
            check($sformatf("%s lat[%0d]", tag, k), 32'(v_cyc[idx] - pix_fall[k]), 32'(VALID_LAT));
        end
        check($sformatf("%s overflow", tag), 32'(o_cnt - ob), 32'((n > NUM_LEDS) ? n - NUM_LEDS : 0));
        check($sformatf("%s frame_done", tag), 32'(d_cnt - db), 32'((n > 0 && partial == 0) ? 1 : 0));
        check($sformatf("%s frame_err", tag), 32'(e_cnt - eb), 32'((partial > 0) ? 1 : 0));
        if (n > 0 && partial == 0)
            check($sformatf("%s done_lat", tag), 32'(d_cyc - last_fall), 32'(GAP_LAT));
`ifdef WS2812_DEC_FORWARD_EN
        check($sformatf("%s dout_high", tag), 32'(dh_cnt - dhb), 32'(fwd_exp));
`endif
        $display("frame %s: pixels=%0d partial_bits=%0d valids=%0d", tag, n, partial, v_cnt - vb);
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k <= n && k < 16; k++) exp_pix[k] = 24'($urandom);
    endtask

    initial begin
        int vb, db, eb, n, partial;

        // Reset state.
        din   = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset rgb",   32'(rgb_data),   32'h0);
        check("reset led",   32'(led_num),    32'h0);
        check("reset valid", 32'(valid),      32'h0);
        check("reset done",  32'(frame_done), 32'h0);
        check("reset err",   32'(frame_err),  32'h0);
        check("reset ovf",   32'(overflow),   32'h0);
        reset = 1'b0;
        repeat (620) @(negedge clk);

        // Single known pixel.
        exp_pix[0] = 24'hABCDEF;
        run_frame("basic", 1, 0, 0);

        // Eight sequential pixels.
        for (int k = 0; k < 8; k++) exp_pix[k] = 24'(k + 1);
        run_frame("eight", 8, 0, 0);

        // Threshold boundary on the first bit.
        fill_random(1);
        run_frame("thr7", 1, 0, 7);
        fill_random(1);
        run_frame("thr8", 1, 0, 8);
        fill_random(1);
        run_frame("hi59", 1, 0, T_HIGH_MAX - 1);

        // Partial word at the gap, then a clean pixel.
        fill_random(1);
        run_frame("partial", 0, 12, 0);
        fill_random(1);
        run_frame("after_partial", 1, 0, 0);

        // Overflow beyond NUM_LEDS.
        fill_random(9);
        run_frame("overflow", 9, 0, 0);

        // Randomised frames.
        for (int f = 0; f < 4; f++) begin
            n       = int'($urandom_range(11, 1));
            partial = ($urandom_range(3, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
            fill_random(n);
            run_frame($sformatf("rand%0d", f), n, partial, 0);
        end

        // Reset in the middle of a pixel, then pulses without a gap.
        vb = v_cnt; db = d_cnt; eb = e_cnt;
        fill_random(2);
        send_word(exp_pix[0], 10, 0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset rgb",   32'(rgb_data), 32'h0);
        check("midreset led",   32'(led_num),  32'h0);
        check("midreset valid", 32'(valid),    32'h0);
        reset = 1'b0;
        send_word(exp_pix[1], 24, 0, 1'b0);
        send_word(exp_pix[2], 24, 0, 1'b0);
        repeat (100) @(negedge clk);
        check("midreset no_valid", 32'(v_cnt - vb), 32'h0);
        repeat (620) @(negedge clk);
        check("midreset silent_done", 32'(d_cnt - db), 32'h0);
        check("midreset silent_err",  32'(e_cnt - eb), 32'h0);
        $display("midreset: valids=%0d done=%0d err=%0d", v_cnt - vb, d_cnt - db, e_cnt - eb);
        fill_random(1);
        run_frame("post_reset", 1, 0, 0);

        // High-pulse fault in the middle of a frame.
        vb = v_cnt; db = d_cnt; eb = e_cnt;
        fill_random(1);
        send_word(exp_pix[0], 5, 0, 1'b0);
        send_bit(T_HIGH_MAX);
        repeat (620) @(negedge clk);
        check("fault err",   32'(e_cnt - eb), 32'h1);
        check("fault done",  32'(d_cnt - db), 32'h0);
        check("fault valid", 32'(v_cnt - vb), 32'h0);
        $display("fault: err=%0d done=%0d valids=%0d", e_cnt - eb, d_cnt - db, v_cnt - vb);
        fill_random(1);
        run_frame("post_fault", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
